// File: rtl/dcache_readback.sv
// Streams a burst of words out of the data memory: one read per word, each word
// held on a valid/ready output until the consumer accepts it.
module dcache_readback #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt, addr_hold;
  logic [CNT_W-1:0]  rem_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_count == '0) ? FINISH : ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      // rem_cnt was already decremented in CAPTURE for the word now held
      HOLD:    if (out_ready) state_nxt = (rem_cnt == '0) ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // rd_addr shows the live counter while reading, else the last issued address
  assign rd_en   = (state == ISSUE);
  assign rd_addr = rd_en ? addr_cnt : addr_hold;
  assign busy    = (state != IDLE);
  assign done    = (state == FINISH) && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      addr_hold <= '0;
      rem_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          addr_cnt <= base_addr;
          rem_cnt  <= word_count;
        end
        ISSUE: addr_hold <= addr_cnt;
        CAPTURE: if (!abort) begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          addr_cnt  <= addr_cnt + ADDR_W'(1);
          rem_cnt   <= rem_cnt - CNT_W'(1);
        end
        HOLD: if (out_ready || abort) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_readback.sv
// Scoreboard bench for dcache_readback: a 16-word memory model answers reads,
// expected addresses/words are queued at start and popped as the DUT produces them.
`timescale 1ns/1ps
module tb_dcache_readback;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        abort = 1'b0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  dcache_readback #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  logic [31:0] addr_q [$];
  logic [31:0] data_q [$];
  int n_checks = 0, n_err = 0;
  int rd_en_cnt = 0, hs_cnt = 0, stall_cnt = 0, done_cnt = 0;
  logic p_rst = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_abort = 1'b0;
  logic [31:0] p_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory answers one cycle after rd_en; junk otherwise so stale use shows up
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[3:0]] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (rst) begin
      if (rd_en) begin
        rd_en_cnt++;
        if (addr_q.size() == 0) chk("rd_en_unexpected", 1, 0);
        else chk("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (data_q.size() == 0) chk("handshake_unexpected", 1, 0);
        else chk("out_data", out_data, data_q.pop_front());
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (done) done_cnt++;
      if (p_rst && p_valid && !p_ready && !p_abort) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, p_data);
      end
    end
    p_rst   <= rst;
    p_valid <= out_valid;
    p_ready <= out_ready;
    p_abort <= abort;
    p_data  <= out_data;
  end

  // queue n_addr expected reads and n_data expected words, then pulse start
  task automatic start_burst(input logic [31:0] base, input int cnt, input int n_addr, input int n_data);
    for (int i = 0; i < n_addr; i++) addr_q.push_back(base + 32'(i));
    for (int i = 0; i < n_data; i++) begin
      logic [31:0] a;
      a = base + 32'(i);
      data_q.push_back(mem[a[3:0]]);
    end
    start = 1'b1; base_addr = base; word_count = 16'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    if (!out_valid) chk("timeout_valid", 0, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    if (!done) chk("timeout_done", 0, 1);
  endtask

  initial begin
    int n, rdc0, dc0, hs0, st0;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i * 257 + 7);
    mem[0] = 8; mem[1] = 16; mem[2] = 23; mem[3] = 42; mem[4] = 156;

    #3;
    chk("rst_busy", busy, 0); chk("rst_valid", out_valid, 0); chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0); chk("rst_done", done, 0); chk("rst_out_data", out_data, 0);
    @(posedge clk); #1 rst = 1'b1;

    // full burst, ready held high, latency checks
    @(posedge clk); #1;
    start_burst(0, 5, 5, 5);
    @(negedge clk); chk("lat_rd_en_n1", rd_en, 1);
    @(negedge clk); chk("lat_valid_n2", out_valid, 0);
    @(negedge clk); chk("lat_valid_n3", out_valid, 1);
    wait_done(n);
    chk("rd_en_to_done", n + 2, 15);

    // consumer stalls on the first word for 4 cycles
    @(posedge clk); #1;
    out_ready = 1'b0; rdc0 = rd_en_cnt; st0 = stall_cnt;
    start_burst(3, 2, 2, 2);
    wait_valid();
    chk("stall_word", out_data, 42);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(n);
    chk("stall_cycles", stall_cnt - st0, 4);
    chk("stall_rd_en_pulses", rd_en_cnt - rdc0, 2);

    // zero-length burst
    @(posedge clk); #1;
    rdc0 = rd_en_cnt; hs0 = hs_cnt;
    start_burst(0, 0, 0, 0);
    @(negedge clk); chk("zero_done", done, 1); chk("zero_busy", busy, 1); chk("zero_rd_en", rd_en, 0);
    @(negedge clk); chk("zero_busy_after", busy, 0); chk("zero_done_after", done, 0);
    chk("zero_no_reads", rd_en_cnt - rdc0, 0); chk("zero_no_words", hs_cnt - hs0, 0);

    // address wrap
    @(posedge clk); #1;
    start_burst(32'hFFFF_FFFF, 2, 2, 2);
    wait_done(n);

    // abort while word 2 of 5 is held
    @(posedge clk); #1;
    dc0 = done_cnt; hs0 = hs_cnt;
    start_burst(0, 5, 2, 1);
    n = 0;
    while (hs_cnt == hs0 && n < 50) begin @(negedge clk); n++; end
    chk("abort_first_hs", hs_cnt - hs0, 1);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); chk("abort_valid", out_valid, 0); chk("abort_busy", busy, 0);
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_q_empty", addr_q.size() + data_q.size(), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    start_burst(1, 3, 3, 3);
    wait_done(n);

    // reset in CAPTURE, then a full burst with a start pulsed while busy
    @(posedge clk); #1;
    start_burst(0, 5, 1, 0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("mid_rst_rd_en", rd_en, 0); chk("mid_rst_valid", out_valid, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0); chk("mid_rst_rd_addr", rd_addr, 0); chk("mid_rst_out_data", out_data, 0);
    @(posedge clk); #1 rst = 1'b1;
    start_burst(0, 5, 5, 5);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 7; word_count = 3;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n);
    @(posedge clk); #1;
    chk("busy_after_burst", busy, 0);

    chk("final_q_empty", addr_q.size() + data_q.size(), 0);
    chk("done_pulses", done_cnt, 6);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_readback.md
DCACHE_READBACK -- requirements
Module: dcache_readback

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the word address.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data word width.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the word-count field.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-006 Port start  input  1  one-cycle request to begin a readback burst.
REQ-007 Port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-008 Port word_count  input  CNT_W  number of words to read, sampled with start.
REQ-009 Port abort  input  1  terminates the burst in progress.
REQ-010 Port rd_en  output  1  data-memory read strobe, one cycle per word.
REQ-011 Port rd_addr  output  ADDR_W  word address accompanying rd_en.
REQ-012 Port rd_data  input  DATA_W  memory read data, valid exactly one cycle after rd_en.
REQ-013 Port out_data  output  DATA_W  streamed word.
REQ-014 Port out_valid  output  1  out_data valid.
REQ-015 Port out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
REQ-016 Port busy  output  1  burst in progress.
REQ-017 Port done  output  1  one-cycle pulse on normal burst completion.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD and FINISH.
REQ-019 IDLE: when start=1, the block SHALL latch base_addr into the address counter, latch word_count into the remaining counter and go to ISSUE; if word_count=0 it SHALL go to FINISH instead.
REQ-020 ISSUE: the block SHALL assert rd_en=1 for exactly one cycle with rd_addr equal to the address counter, then go to CAPTURE.
REQ-021 CAPTURE: the block SHALL register rd_data into out_data, set out_valid=1, increment the address counter, decrement the remaining counter, then go to HOLD.
REQ-022 HOLD: the block SHALL keep out_valid and out_data stable until out_ready=1; on acceptance it SHALL drop out_valid and go to ISSUE if words remain, else to FINISH.
REQ-023 FINISH: the block SHALL assert done=1 for one cycle, then go to IDLE.
REQ-024 Latency SHALL be as follows: start in cycle N, rd_en in cycle N+1, out_valid first high in cycle N+3; with out_ready held at 1, throughput is one word per 3 cycles.
REQ-025 rd_en SHALL be 0 in every state other than ISSUE; rd_addr SHALL hold its last value when rd_en=0.
REQ-026 busy SHALL be 1 in ISSUE, CAPTURE, HOLD and FINISH, and 0 in IDLE.
REQ-027 start SHALL be ignored while busy=1, with no effect on the counters or the stream.
REQ-028 The address counter SHALL wrap modulo 2^ADDR_W; no error is flagged on wrap.
REQ-029 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with out_valid=0, rd_en=0 and no done pulse; an in-flight rd_data is discarded.
REQ-030 If abort and start are both 1 while in IDLE, start SHALL win; abort in IDLE SHALL have no effect.
REQ-031 A word SHALL never be emitted twice or skipped: exactly word_count handshakes occur per non-aborted burst, in ascending address order.

Reset
REQ-032 While rst=0 the block SHALL asynchronously force state=IDLE, out_valid=0, out_data=0, rd_en=0, rd_addr=0, busy=0, done=0, and both counters to 0.
REQ-033 Assertion of rst mid-burst SHALL abandon the burst; after release the block SHALL accept a new start in the first cycle.
REQ-034 Release of rst SHALL take effect on the rising edge after rst returns to 1; no output glitches above 0 during reset.

Verification
REQ-035 Memory preloaded with 8,16,23,42,156 at 0..4; start with base=0, count=5, out_ready=1 -> out_data sequence 8,16,23,42,156, rd_addr 0..4, done one cycle after the last handshake, 15 cycles from rd_en to done.
REQ-036 Same preload; base=3, count=2, out_ready low for 4 cycles on the first word -> 42 held stable for 4 cycles, then 156, then done; exactly 2 rd_en pulses.
REQ-037 start with count=0 -> no rd_en, no out_valid, done pulses in cycle N+1, busy high for 1 cycle.
REQ-038 base=2^ADDR_W-1, count=2 -> rd_addr sequence FFFFFFFF then 00000000.
REQ-039 abort asserted during HOLD of word 2 of 5 -> out_valid drops next cycle, no done, busy=0; a subsequent start re-reads from its new base correctly.
REQ-040 rst driven low during CAPTURE -> all outputs 0 immediately without waiting for clk; start after release yields a full correct burst; start pulsed while busy -> ignored.
